// File: rtl/exec_pkg.sv
// Shared opcodes, condition-code bit positions and state encodings for the
// VeSPA execute stage.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  localparam int CC_C = 3;
  localparam int CC_Z = 2;
  localparam int CC_N = 1;
  localparam int CC_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } mdMode_t;

  function automatic logic isMulDiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exec_unit_mc_iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// hiReg/loReg hold {product high, product low} or {remainder, quotient}.
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Abort,
  input  logic              i_Start,
  input  mdMode_t           i_Mode,
  input  logic [DATA_W-1:0] i_Op1,
  input  logic [DATA_W-1:0] i_Op2,
  output logic              o_Done,
  output logic [DATA_W-1:0] o_Result,
  output logic              o_HiNonZero,
  output logic              o_DivZero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mdMode_t           mode;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;
  logic [DATA_W-1:0] opB;

  logic [DATA_W:0]   mulSum;
  logic [DATA_W:0]   divShift;
  logic [DATA_W:0]   divDiff;

  assign mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, opB} : '0);
  assign divShift = {hiReg, loReg[DATA_W-1]};
  assign divDiff  = divShift - {1'b0, opB};

  // A zero divisor never borrows, so the quotient fills with ones and the
  // dividend shifts intact into the remainder without any special casing.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode  <= MD_MUL;
      cnt   <= '0;
      hiReg <= '0;
      loReg <= '0;
      opB   <= '0;
    end else if (i_Abort) begin
      cnt <= '0;
    end else if (i_Start) begin
      mode  <= i_Mode;
      cnt   <= CNT_W'(DATA_W);
      hiReg <= '0;
      loReg <= i_Op1;
      opB   <= i_Op2;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (mode == MD_MUL) begin
        {hiReg, loReg} <= {mulSum, loReg[DATA_W-1:1]};
      end else if (!divDiff[DATA_W]) begin
        hiReg <= divDiff[DATA_W-1:0];
        loReg <= {loReg[DATA_W-2:0], 1'b1};
      end else begin
        hiReg <= divShift[DATA_W-1:0];
        loReg <= {loReg[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign o_Done      = (cnt == CNT_W'(1));
  assign o_Result    = (mode == MD_REMU) ? hiReg : loReg;
  assign o_HiNonZero = |hiReg;
  assign o_DivZero   = (opB == '0);

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit: operand forwarding, single-cycle ALU, iterative
// mul/div, valid/ready handshake towards decode and MEM.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int FWD_SRCS = 3,
  localparam int SEL_W    = $clog2(FWD_SRCS + 1)
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Flush,
  input  logic                       i_Valid,
  output logic                       o_Ready,
  input  logic [3:0]                 i_AluCtrl,
  input  logic                       i_Op2Sel,
  input  logic                       i_UpdateCondCodes,
  input  logic [DATA_W-1:0]          i_R1Out,
  input  logic [DATA_W-1:0]          i_R2Out,
  input  logic [FWD_SRCS*DATA_W-1:0] i_FwdBus,
  input  logic [SEL_W-1:0]           i_FwdSel1,
  input  logic [SEL_W-1:0]           i_FwdSel2,
  input  logic [DATA_W-1:0]          i_Imm,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [DATA_W-1:0]          o_Result,
  output logic [DATA_W-1:0]          o_Op2,
  output logic [3:0]                 o_CondCodes,
  output logic                       o_Busy
);

  localparam int SH_W = $clog2(DATA_W);

  state_t            state;
  logic              isMulLat;
  logic              uccLat;
  logic [DATA_W-1:0] op2Lat;

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opTwo;
  logic [DATA_W-1:0] opB;
  logic [SH_W-1:0]   shAmt;
  logic [DATA_W-1:0] aluRes;
  logic              aluC;
  logic              aluV;

  logic              accept;
  logic              loadEn;
  logic [DATA_W-1:0] ldRes;
  logic [DATA_W-1:0] ldOp2;
  logic              ldUcc;
  logic              ldC;
  logic              ldV;
  logic [3:0]        ldCc;

  mdMode_t           mdMode;
  logic              mdStart;
  logic              mdDone;
  logic [DATA_W-1:0] mdResult;
  logic              mdHiNonZero;
  logic              mdDivZero;

  // Selects beyond the last forwarding source fall back to the register file.
  function automatic logic [DATA_W-1:0] selOperand(
    input logic [SEL_W-1:0]           sel,
    input logic [DATA_W-1:0]          regVal,
    input logic [FWD_SRCS*DATA_W-1:0] fwdBus
  );
    logic [DATA_W-1:0] val;
    val = regVal;
    for (int k = 0; k < FWD_SRCS; k++) begin
      if (int'(sel) == k + 1) val = fwdBus[k*DATA_W +: DATA_W];
    end
    return val;
  endfunction

  assign opA   = selOperand(i_FwdSel1, i_R1Out, i_FwdBus);
  assign opTwo = selOperand(i_FwdSel2, i_R2Out, i_FwdBus);
  assign opB   = i_Op2Sel ? i_Imm : opTwo;
  assign shAmt = opB[SH_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (i_AluCtrl)
      OP_ADD: begin
        {aluC, aluRes} = {1'b0, opA} + {1'b0, opB};
        aluV = (opA[DATA_W-1] == opB[DATA_W-1]) && (aluRes[DATA_W-1] != opA[DATA_W-1]);
      end
      OP_SUB: begin
        {aluC, aluRes} = {1'b0, opA} + {1'b0, ~opB} + (DATA_W + 1)'(1);
        aluV = (opA[DATA_W-1] != opB[DATA_W-1]) && (aluRes[DATA_W-1] != opA[DATA_W-1]);
      end
      OP_AND: aluRes = opA & opB;
      OP_OR:  aluRes = opA | opB;
      OP_XOR: aluRes = opA ^ opB;
      OP_NOT: aluRes = ~opA;
      OP_MOV: aluRes = opB;
      OP_SHL: {aluC, aluRes} = {1'b0, opA} << shAmt;
      OP_SHR: {aluRes, aluC} = {opA, 1'b0} >> shAmt;
      default: aluRes = '0;
    endcase
  end

  assign o_Ready = (state == ST_IDLE) && (!o_Valid || i_Ready) && !i_Flush;
  assign o_Busy  = (state != ST_IDLE);
  assign accept  = i_Valid && o_Ready;
  assign mdStart = accept && isMulDiv(i_AluCtrl);
  assign mdMode  = (i_AluCtrl == OP_MUL)  ? MD_MUL  :
                   (i_AluCtrl == OP_DIVU) ? MD_DIVU : MD_REMU;
  assign loadEn  = !i_Flush &&
                   ((state == ST_DONE) || (accept && !isMulDiv(i_AluCtrl)));

  // Output-register payload: the finishing long op in DONE, otherwise the
  // single-cycle instruction being accepted.
  always_comb begin
    ldCc = '0;
    if (state == ST_DONE) begin
      ldRes = mdResult;
      ldOp2 = op2Lat;
      ldUcc = uccLat;
      ldC   = 1'b0;
      ldV   = isMulLat ? mdHiNonZero : mdDivZero;
    end else begin
      ldRes = aluRes;
      ldOp2 = opTwo;
      ldUcc = i_UpdateCondCodes && (i_AluCtrl <= OP_REMU);
      ldC   = aluC;
      ldV   = aluV;
    end
    ldCc[CC_C] = ldC;
    ldCc[CC_Z] = (ldRes == '0);
    ldCc[CC_N] = ldRes[DATA_W-1];
    ldCc[CC_V] = ldV;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      isMulLat    <= 1'b0;
      uccLat      <= 1'b0;
      op2Lat      <= '0;
      o_Valid     <= 1'b0;
      o_Result    <= '0;
      o_Op2       <= '0;
      o_CondCodes <= '0;
    end else if (i_Flush) begin
      state   <= ST_IDLE;
      o_Valid <= 1'b0;
    end else begin
      if (o_Valid && i_Ready) o_Valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mdStart) begin
            state    <= (i_AluCtrl == OP_MUL) ? ST_MUL : ST_DIV;
            isMulLat <= (i_AluCtrl == OP_MUL);
            uccLat   <= i_UpdateCondCodes;
            op2Lat   <= opTwo;
          end
        end
        ST_MUL, ST_DIV: if (mdDone) state <= ST_DONE;
        ST_DONE:        state <= ST_IDLE;
        default:        state <= ST_IDLE;
      endcase
      if (loadEn) begin
        o_Valid  <= 1'b1;
        o_Result <= ldRes;
        o_Op2    <= ldOp2;
        if (ldUcc) o_CondCodes <= ldCc;
      end
    end
  end

  iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Abort     (i_Flush),
    .i_Start     (mdStart),
    .i_Mode      (mdMode),
    .i_Op1       (opA),
    .i_Op2       (opB),
    .o_Done      (mdDone),
    .o_Result    (mdResult),
    .o_HiNonZero (mdHiNonZero),
    .o_DivZero   (mdDivZero)
  );

endmodule
